// File: rtl/seq_det_arbiter_if.sv
// Bundle between the two serial requesters, the shared 11011 detector and the arbiter.
// The irq_clr/irq pair exists only when SEQ_DET_IRQ_EN is defined.
interface seq_det_arbiter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req0;
  logic             bit0;
  logic             req1;
  logic             bit1;
  logic             gnt0;
  logic             gnt1;
  logic             det_in;
  logic             det_rst;
  logic             det_out;
  logic             match0;
  logic             match1;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             busy;
  logic             frame_done;
`ifdef SEQ_DET_IRQ_EN
  logic             irq_clr;
  logic             irq;

  modport slave (
    input  req0, bit0, req1, bit1, det_out, irq_clr,
    output gnt0, gnt1, det_in, det_rst, match0, match1, cnt0, cnt1, busy, frame_done, irq
  );
  modport master (
    output req0, bit0, req1, bit1, det_out, irq_clr,
    input  gnt0, gnt1, det_in, det_rst, match0, match1, cnt0, cnt1, busy, frame_done, irq
  );
`else
  modport slave (
    input  req0, bit0, req1, bit1, det_out,
    output gnt0, gnt1, det_in, det_rst, match0, match1, cnt0, cnt1, busy, frame_done
  );
  modport master (
    output req0, bit0, req1, bit1, det_out,
    input  gnt0, gnt1, det_in, det_rst, match0, match1, cnt0, cnt1, busy, frame_done
  );
`endif
endinterface

// File: rtl/seq_det_arbiter.sv
// Round-robin frame arbiter sharing one Moore "11011" detector between two serial channels,
// with per-channel saturating hit counters. Optional sticky irq under SEQ_DET_IRQ_EN.
module seq_det_arbiter #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_det_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLR    = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam logic [7:0]       LAST_BIT = 8'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic             match0_q, match0_d;
  logic             match1_q, match1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             streaming;
  logic             hit;

  assign streaming = (state_q == STREAM);

  always_comb begin
    // NOTE: every _d is given its hold value first so no branch can leave it unassigned (no latch).
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = CLR;
          sel_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        end
      end
      CLR: begin
        state_d   = STREAM;
        bit_cnt_d = '0;
      end
      STREAM: begin
        if (bit_cnt_q == LAST_BIT) state_d = DRAIN;
        else                       bit_cnt_d = bit_cnt_q + 8'd1;
      end
      DRAIN: begin
        state_d = IDLE;
        last_d  = sel_q;
      end
      default: state_d = IDLE;
    endcase

    // The first STREAM cycle still shows the cleared detector, so its output is skipped.
    hit      = bus.det_out & ((streaming && (bit_cnt_q != 8'd0)) || (state_q == DRAIN));
    match0_d = hit & ~sel_q;
    match1_d = hit & sel_q;

    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (match0_d && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_ONE;
    if (match1_d && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      bit_cnt_q <= '0;
      match0_q  <= 1'b0;
      match1_q  <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      match0_q  <= match0_d;
      match1_q  <= match1_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  // Grants and detector controls decode from state only; det_in masks a dropped request.
  assign bus.gnt0       = streaming & ~sel_q;
  assign bus.gnt1       = streaming & sel_q;
  assign bus.det_rst    = (state_q == IDLE) || (state_q == CLR);
  assign bus.det_in     = streaming & (sel_q ? (bus.bit1 & bus.req1) : (bus.bit0 & bus.req0));
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = (state_q == DRAIN);
  assign bus.match0     = match0_q;
  assign bus.match1     = match1_q;
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;

`ifdef SEQ_DET_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (match0_q || match1_q) irq_d = 1'b1;
    else if (bus.irq_clr)     irq_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter: two DUTs (CNT_W=8 and CNT_W=2) share stimulus,
// each with its own behavioural 11011 non-overlapping Moore detector.
module tb_seq_det_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1, bit0, bit1, irq_clr;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_det_arbiter_if #(.CNT_W(8)) bus_a ();
  seq_det_arbiter_if #(.CNT_W(2)) bus_b ();

  seq_det_arbiter #(.FRAME_LEN(16), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  seq_det_arbiter #(.FRAME_LEN(16), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic [2:0] ds_a = 3'd0;
  logic [2:0] ds_b = 3'd0;

  assign bus_a.req0 = req0;  assign bus_a.req1 = req1;
  assign bus_a.bit0 = bit0;  assign bus_a.bit1 = bit1;
  assign bus_b.req0 = req0;  assign bus_b.req1 = req1;
  assign bus_b.bit0 = bit0;  assign bus_b.bit1 = bit1;
  assign bus_a.det_out = (ds_a == 3'd5);
  assign bus_b.det_out = (ds_b == 3'd5);
`ifdef SEQ_DET_IRQ_EN
  assign bus_a.irq_clr = irq_clr;
  assign bus_b.irq_clr = irq_clr;
`endif

  // Reference detector: after a match it restarts from scratch (non-overlapping).
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd2 : 3'd0;
      3'd2:    return b ? 3'd2 : 3'd3;
      3'd3:    return b ? 3'd4 : 3'd0;
      3'd4:    return b ? 3'd5 : 3'd0;
      default: return b ? 3'd1 : 3'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    ds_a <= bus_a.det_rst ? 3'd0 : det_next(ds_a, bus_a.det_in);
    ds_b <= bus_b.det_rst ? 3'd0 : det_next(ds_b, bus_b.det_in);
  end

  // Serial sources: each granted cycle emits the next bit of the loaded frames, MSB first.
  logic [15:0] frm0 [4];
  logic [15:0] frm1 [4];
  int p0, f0, p1, f1;

  always @(negedge clk) begin
    if (!rst_n) begin
      p0 <= 0; f0 <= 0; p1 <= 0; f1 <= 0;
      bit0 <= 1'b0; bit1 <= 1'b0;
    end else begin
      if (bus_a.gnt0) begin
        bit0 <= (f0 < 4) ? frm0[f0][15-p0] : 1'b0;
        if (p0 == 15) begin p0 <= 0; f0 <= f0 + 1; end
        else p0 <= p0 + 1;
      end else bit0 <= 1'b0;
      if (bus_a.gnt1) begin
        bit1 <= (f1 < 4) ? frm1[f1][15-p1] : 1'b0;
        if (p1 == 15) begin p1 <= 0; f1 <= f1 + 1; end
        else p1 <= p1 + 1;
      end else bit1 <= 1'b0;
    end
  end

  // Observation counters, cleared by reset.
  int         ovl, g0n, g1n, m0n, m1n, mb0n, n_ord, idle_run;
  logic       ord [8];
  int         gap [8];
  logic [1:0] cntb_at [8];
  logic       prev_any;
  wire        any_gnt = bus_a.gnt0 | bus_a.gnt1;

  always @(negedge clk) begin
    if (!rst_n) begin
      ovl <= 0; g0n <= 0; g1n <= 0; m0n <= 0; m1n <= 0; mb0n <= 0;
      n_ord <= 0; idle_run <= 0; prev_any <= 1'b0;
    end else begin
      if (bus_a.gnt0 && bus_a.gnt1) ovl <= ovl + 1;
      if (bus_a.gnt0) g0n <= g0n + 1;
      if (bus_a.gnt1) g1n <= g1n + 1;
      if (any_gnt && !prev_any) begin
        if (n_ord < 8) begin
          ord[n_ord] <= bus_a.gnt1;
          if (n_ord > 0) gap[n_ord-1] <= idle_run;
        end
        n_ord    <= n_ord + 1;
        idle_run <= 0;
      end else if (!any_gnt) idle_run <= idle_run + 1;
      prev_any <= any_gnt;
      if (bus_a.match0) m0n <= m0n + 1;
      if (bus_a.match1) m1n <= m1n + 1;
      if (bus_b.match0) begin
        if (mb0n < 8) cntb_at[mb0n] <= bus_b.cnt0;
        mb0n <= mb0n + 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_frames();
    for (int i = 0; i < 4; i++) begin
      frm0[i] = 16'h0000;
      frm1[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; irq_clr = 1'b0;
    clear_frames();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; irq_clr = 1'b0;
    clear_frames();
    repeat (2) @(posedge clk);
    #2;
    total++; if (bus_a.gnt0 !== 1'b0)       begin bad++; $display("FAIL rst_gnt0 got=%b want=0", bus_a.gnt0); end
    total++; if (bus_a.gnt1 !== 1'b0)       begin bad++; $display("FAIL rst_gnt1 got=%b want=0", bus_a.gnt1); end
    total++; if (bus_a.det_rst !== 1'b1)    begin bad++; $display("FAIL rst_det_rst got=%b want=1", bus_a.det_rst); end
    total++; if (bus_a.det_in !== 1'b0)     begin bad++; $display("FAIL rst_det_in got=%b want=0", bus_a.det_in); end
    total++; if (bus_a.busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_a.frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b want=0", bus_a.frame_done); end
    total++; if ({bus_a.match0, bus_a.match1} !== 2'b00) begin bad++; $display("FAIL rst_match got=%b want=00", {bus_a.match0, bus_a.match1}); end
    total++; if (bus_a.cnt0 !== 8'd0)       begin bad++; $display("FAIL rst_cnt0 got=%0d want=0", bus_a.cnt0); end
    total++; if (bus_a.cnt1 !== 8'd0)       begin bad++; $display("FAIL rst_cnt1 got=%0d want=0", bus_a.cnt1); end
`ifdef SEQ_DET_IRQ_EN
    total++; if (bus_a.irq !== 1'b0)        begin bad++; $display("FAIL rst_irq got=%b want=0", bus_a.irq); end
`endif
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single_frame();
    do_reset();
    frm0[0] = 16'hD800;
    req0 = 1'b1;
    step(7);
    total++; if (bus_a.match0 !== 1'b0) begin bad++; $display("FAIL single_match_early got=%b want=0", bus_a.match0); end
    step(1);
    total++; if (bus_a.match0 !== 1'b1) begin bad++; $display("FAIL single_match_c7 got=%b want=1", bus_a.match0); end
    total++; if (bus_a.gnt0 !== 1'b1)   begin bad++; $display("FAIL single_gnt0_c7 got=%b want=1", bus_a.gnt0); end
`ifdef SEQ_DET_IRQ_EN
    total++; if (bus_a.irq !== 1'b0)    begin bad++; $display("FAIL irq_before got=%b want=0", bus_a.irq); end
    irq_clr = 1'b1;
`endif
    req0 = 1'b0;
    step(1);
    total++; if (bus_a.match0 !== 1'b0) begin bad++; $display("FAIL single_match_c8 got=%b want=0", bus_a.match0); end
    total++; if (bus_a.cnt0 !== 8'd1)   begin bad++; $display("FAIL single_cnt0 got=%0d want=1", bus_a.cnt0); end
`ifdef SEQ_DET_IRQ_EN
    total++; if (bus_a.irq !== 1'b1)    begin bad++; $display("FAIL irq_set_wins got=%b want=1", bus_a.irq); end
    step(1);
    total++; if (bus_a.irq !== 1'b0)    begin bad++; $display("FAIL irq_clr got=%b want=0", bus_a.irq); end
    irq_clr = 1'b0;
    step(8);
`else
    step(9);
`endif
    total++; if (bus_a.frame_done !== 1'b1) begin bad++; $display("FAIL single_frame_done got=%b want=1", bus_a.frame_done); end
    total++; if (bus_a.gnt0 !== 1'b0)       begin bad++; $display("FAIL single_gnt0_drain got=%b want=0", bus_a.gnt0); end
    step(1);
    total++; if (bus_a.busy !== 1'b0)       begin bad++; $display("FAIL single_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_a.frame_done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%b want=0", bus_a.frame_done); end
    total++; if (g0n !== 16) begin bad++; $display("FAIL single_gnt0_cycles got=%0d want=16", g0n); end
    total++; if (g1n !== 0)  begin bad++; $display("FAIL single_gnt1_cycles got=%0d want=0", g1n); end
    total++; if (m0n !== 1)  begin bad++; $display("FAIL single_match_count got=%0d want=1", m0n); end
  endtask

  task automatic test_req_drop();
    do_reset();
    frm1[0] = 16'hD800;
    req1 = 1'b1;
    step(4);
    req1 = 1'b0;
    step(14);
    total++; if (bus_a.frame_done !== 1'b1) begin bad++; $display("FAIL drop_frame_done got=%b want=1", bus_a.frame_done); end
    step(2);
    total++; if (bus_a.cnt1 !== 8'd0) begin bad++; $display("FAIL drop_cnt1 got=%0d want=0", bus_a.cnt1); end
    total++; if (m1n !== 0)  begin bad++; $display("FAIL drop_matches got=%0d want=0", m1n); end
    total++; if (g1n !== 16) begin bad++; $display("FAIL drop_gnt1_cycles got=%0d want=16", g1n); end
  endtask

  task automatic test_fairness();
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    step(75);
    total++; if (bus_a.frame_done !== 1'b1) begin bad++; $display("FAIL fair_4th_done got=%b want=1", bus_a.frame_done); end
    req0 = 1'b0;
    req1 = 1'b0;
    step(2);
    total++; if (n_ord !== 4) begin bad++; $display("FAIL fair_grants got=%0d want=4", n_ord); end
    for (int i = 0; i < 4; i++) begin
      total++; if (ord[i] !== 1'(i % 2)) begin bad++; $display("FAIL fair_order[%0d] got=%b want=%0d", i, ord[i], i % 2); end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (gap[i] !== 3) begin bad++; $display("FAIL fair_gap[%0d] got=%0d want=3", i, gap[i]); end
    end
    total++; if (ovl !== 0) begin bad++; $display("FAIL fair_overlap got=%0d want=0", ovl); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL fair_busy got=%b want=0", bus_a.busy); end
  endtask

  task automatic test_drain_hit();
    do_reset();
    frm1[0] = 16'h001B;
    req1 = 1'b1;
    step(18);
    total++; if (bus_a.frame_done !== 1'b1) begin bad++; $display("FAIL drain_frame_done got=%b want=1", bus_a.frame_done); end
    total++; if (bus_a.match1 !== 1'b0)     begin bad++; $display("FAIL drain_match_early got=%b want=0", bus_a.match1); end
    req1 = 1'b0;
    step(1);
    total++; if (bus_a.match1 !== 1'b1) begin bad++; $display("FAIL drain_match1 got=%b want=1", bus_a.match1); end
    total++; if (bus_a.busy !== 1'b0)   begin bad++; $display("FAIL drain_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_a.cnt1 !== 8'd1)   begin bad++; $display("FAIL drain_cnt1 got=%0d want=1", bus_a.cnt1); end
    step(1);
    total++; if (bus_a.match1 !== 1'b0) begin bad++; $display("FAIL drain_match_pulse got=%b want=0", bus_a.match1); end
    total++; if (m1n !== 1) begin bad++; $display("FAIL drain_match_count got=%0d want=1", m1n); end
  endtask

  task automatic test_overlap();
    do_reset();
    frm0[0] = 16'hDB00;
    frm0[1] = 16'hDEC0;
    req0 = 1'b1;
    step(19);
    total++; if (bus_a.cnt0 !== 8'd1) begin bad++; $display("FAIL overlap_cnt0_f1 got=%0d want=1", bus_a.cnt0); end
    step(18);
    req0 = 1'b0;
    step(2);
    total++; if (bus_a.cnt0 !== 8'd3) begin bad++; $display("FAIL overlap_cnt0_f2 got=%0d want=3", bus_a.cnt0); end
    total++; if (m0n !== 3) begin bad++; $display("FAIL overlap_matches got=%0d want=3", m0n); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_at [4];
    exp_at[0] = 2'd1; exp_at[1] = 2'd2; exp_at[2] = 2'd3; exp_at[3] = 2'd3;
    do_reset();
    frm0[0] = 16'hDEF6;
    frm0[1] = 16'hD800;
    req0 = 1'b1;
    step(37);
    req0 = 1'b0;
    step(2);
    total++; if (mb0n !== 4) begin bad++; $display("FAIL sat_pulses got=%0d want=4", mb0n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (cntb_at[i] !== exp_at[i]) begin bad++; $display("FAIL sat_cnt_at[%0d] got=%0d want=%0d", i, cntb_at[i], exp_at[i]); end
    end
    total++; if (bus_b.cnt0 !== 2'd3) begin bad++; $display("FAIL sat_cnt_final got=%0d want=3", bus_b.cnt0); end
    total++; if (bus_a.cnt0 !== 8'd4) begin bad++; $display("FAIL sat_wide_cnt got=%0d want=4", bus_a.cnt0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    frm0[0] = 16'hD800;
    req0 = 1'b1;
    step(9);
    total++; if (bus_a.cnt0 !== 8'd1) begin bad++; $display("FAIL ar_cnt0_pre got=%0d want=1", bus_a.cnt0); end
    total++; if (bus_a.gnt0 !== 1'b1) begin bad++; $display("FAIL ar_gnt0_pre got=%b want=1", bus_a.gnt0); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus_a.gnt0 !== 1'b0)    begin bad++; $display("FAIL ar_gnt0 got=%b want=0", bus_a.gnt0); end
    total++; if (bus_a.busy !== 1'b0)    begin bad++; $display("FAIL ar_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_a.cnt0 !== 8'd0)    begin bad++; $display("FAIL ar_cnt0 got=%0d want=0", bus_a.cnt0); end
    total++; if (bus_a.det_rst !== 1'b1) begin bad++; $display("FAIL ar_det_rst got=%b want=1", bus_a.det_rst); end
    clear_frames();
    req0 = 1'b1;
    req1 = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(3);
    total++; if (bus_a.gnt0 !== 1'b1) begin bad++; $display("FAIL ar_tie_gnt0 got=%b want=1", bus_a.gnt0); end
    total++; if (bus_a.gnt1 !== 1'b0) begin bad++; $display("FAIL ar_tie_gnt1 got=%b want=0", bus_a.gnt1); end
    req0 = 1'b0;
    req1 = 1'b0;
    step(20);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_req_drop();
    test_fairness();
    test_drain_hit();
    test_overlap();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_det_arbiter.md
Name: seq_det_arbiter

Overview:
- Shares one Moore non-overlapping "11011" serial pattern detector between two serial bit-stream requesters.
- Grants the detector to one requester per frame of FRAME_LEN bits, round-robin.
- Clears the detector before each frame and attributes detector hits to the granted channel.
- Keeps per-channel saturating match counters.
- Sits between the serial sources and the detector instance.

Parameters:
- FRAME_LEN, 16, bits streamed per grant; legal range 5..255.
- CNT_W, 8, width of each per-channel match counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req0  input  1  channel 0 requests a frame; level, held while data pending.
- bit0  input  1  channel 0 serial data, valid every cycle gnt0=1.
- req1  input  1  channel 1 request.
- bit1  input  1  channel 1 serial data.
- gnt0  output  1  channel 0 must drive bit0 this cycle.
- gnt1  output  1  channel 1 must drive bit1 this cycle.
- det_in  output  1  serial bit to detector.
- det_rst  output  1  active-high clear to detector.
- det_out  input  1  detector Moore output; 1 while in match state.
- match0  output  1  one-cycle pulse, channel 0 hit.
- match1  output  1  one-cycle pulse, channel 1 hit.
- cnt0  output  CNT_W  channel 0 match count, saturating.
- cnt1  output  CNT_W  channel 1 match count, saturating.
- busy  output  1  high in any state except IDLE.
- frame_done  output  1  one-cycle pulse at end of DRAIN.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, last=1 (so channel 0 wins the first tie).
  - All outputs 0 except det_rst=1.
  - cnt0=cnt1=0.
- FSM states: IDLE, CLR, STREAM, DRAIN. All outputs are registered or decoded from state only; no combinational path from req to gnt.
- IDLE:
  - det_rst=1.
  - Only req0 → sel=0. Only req1 → sel=1. Both high → sel=~last. Neither → stay in IDLE.
  - On any grant go to CLR.
- CLR: exactly 1 cycle, det_rst=1, gnt=0. Guarantees the detector starts in S0.
- STREAM:
  - Exactly FRAME_LEN cycles, tracked by an internal counter.
  - gnt[sel]=1, det_rst=0.
  - det_in = bit[sel] & req[sel]. A requester that drops req mid-frame does not abort the frame; remaining bits are forced to 0.
  - After the last STREAM cycle go to DRAIN.
- DRAIN:
  - 1 cycle, gnt=0, det_in=0. Needed to observe the Moore output produced by the final bit.
  - frame_done=1, last<=sel, next state IDLE.
- Match capture:
  - det_out is sampled in every STREAM cycle except the first, and in DRAIN.
  - A sampled 1 produces match[sel]=1 on the following cycle and increments cnt[sel].
  - Counter saturates at 2^CNT_W-1 and does not wrap.
  - In the first STREAM cycle det_out is ignored; it is 0 after CLR anyway.
- Frame period: FRAME_LEN+3 cycles including IDLE; back-to-back grants therefore have a 3-cycle gap.
- A request arriving during a frame waits for IDLE. Fairness: with both requesting continuously, grants strictly alternate 0,1,0,1.
- gnt0 and gnt1 are never high together.

Optional Feature:
- Macro SEQ_DET_IRQ_EN.
- When defined, two extra ports exist:
  - irq_clr  input  1: synchronous clear of irq.
  - irq  output  1: sticky flag, set the cycle after any match0/match1 pulse.
  - If set and clear coincide, set wins.
  - irq resets to 0.
- When not defined, neither port exists and no irq logic is built.

Test Plan:
- FRAME_LEN=16, req0 only, bit0 stream 1,1,0,1,1 then eleven 0s → gnt0 high 16 cycles; match0 pulses once, in STREAM cycle 7; cnt0=1; frame_done after 18 cycles; gnt1 never high.
- req0 and req1 both held high for 4 frames → grant order 0,1,0,1; 3-cycle gap between frames; gnt0&gnt1 never 1.
- ch1 streams eleven 0s then 1,1,0,1,1 (pattern in the last 5 bits) → hit captured in DRAIN; match1 pulses one cycle after DRAIN; cnt1=1.
- ch0 streams 1,1,0,1,1,0,1,1 (overlap case) → cnt0=1 only, non-overlapping semantics; then 1,1,0,1,1,1,1,0,1,1 → cnt0=3.
- CNT_W=2, ch0 sends 4 separate 11011 patterns → cnt0 reads 1,2,3,3; match0 still pulses 4 times.
- rst_n low in STREAM cycle 8 → gnt0, busy, cnt0 go to 0 immediately and det_rst goes to 1; after release, first tie is granted to channel 0. With SEQ_DET_IRQ_EN defined: irq=1 after the first match, cleared by irq_clr.
